key_sched_ctrl: RTL and testbench
=================================

// Module: key_sched_ctrl
// PURPOSE
//  Sequential AES-128 key-schedule controller.
//  - Accepts a cipher key over a start/ready handshake.
//  - Expands it one round key per cycle through a single shared SubWord datapath (4 S-boxes, not 40).
//  - Holds all 11 round keys in an internal buffer; the cipher datapath reads them by round index.
// PARAMETERS
//  LENGTH  128  key width in bits; only 128 is supported
//  Nb      4    state columns (32-bit words per round key)
//  Nr      10   number of rounds; the buffer holds Nr+1 round keys
//  IDX_W   4    width of the round-index read port
// PORTS
//  clk          in   1         clock; all state updates on the rising edge
//  rst_n        in   1         asynchronous, active-low reset
//  start        in   1         request a new expansion; accepted when start && ready
//  key          in   LENGTH    cipher key, sampled on acceptance; key[127:96] = w0 (FIPS-197 order)
//  ready        out  1         controller can accept start (states IDLE, DONE)
//  busy         out  1         expansion in progress (state EXPAND)
//  done         out  1         one-cycle pulse when round key Nr has been written
//  key_valid    out  1         level; buffer holds a complete schedule for the last accepted key
//  rk_rd_idx    in   IDX_W     round-key read index, 0..Nr
//  rk_rd_data   out  LENGTH    round key rk_rd_idx (combinational read); 0 when idx > Nr
//  zeroize      in   1         present only with KEYSCHED_ZEROIZE_EN
// BEHAVIOUR
//  - Reset values: ready=1, busy=0, done=0, key_valid=0, all buffer entries=0, state=IDLE, round=0, rcon=8'h01.
//  - States: IDLE -> EXPAND (on start accepted); EXPAND -> DONE (after round Nr is written);
//    DONE -> EXPAND (on start accepted).
//  - Acceptance (cycle 0): rk[0] <= key; round <= 1; rcon <= 8'h01; key_valid <= 0.
//  - EXPAND, cycle r (r = 1..Nr), computing rk[r] from rk[r-1] = {p0,p1,p2,p3}:
//    t = SubWord(RotWord(p3)) ^ {rcon,24'h0}; n0 = p0^t; n1 = p1^n0; n2 = p2^n1; n3 = p3^n2.
//    rk[r] <= {n0,n1,n2,n3}.
//  - rcon update after each round: rcon <= xtime(rcon); 8'h80 -> 8'h1b (reduction polynomial 0x11b).
//  - Latency: rk[Nr] is written at the end of cycle Nr (cycle 10).
//    In cycle 11: done=1 and key_valid=1, state=DONE.
//  - Start timing:
//    - start while busy: ignored (ready=0); the expansion in progress completes unaffected.
//    - start in DONE: accepted; key_valid falls the next cycle; the old schedule is overwritten round by round.
//  - Read port:
//    - Purely combinational.
//    - Reads during EXPAND return the current, partially updated buffer contents; consumers gate on key_valid.
//    - Index > Nr returns all zeros.
//  - Reset asserted mid-expansion: returns to the reset state immediately (asynchronous reset);
//    no partial-schedule state survives.
// CONFIGURATION
//  - KEYSCHED_ZEROIZE_EN defined: adds input port zeroize.
//    - When zeroize=1 at a clock edge: all rk entries <= 0; state <= IDLE; key_valid <= 0; done <= 0.
//    - Aborts an expansion in progress.
//    - Has priority over start in the same cycle.
//  - KEYSCHED_ZEROIZE_EN undefined: no zeroize port. Buffer contents persist until overwritten by the
//    next accepted key or by reset.
// STRUCTURE
//  - Shared package aes_pkg:
//    - constants Nb, Nk, Nr, RCON_INIT = 8'h01;
//    - typedef word_t (32 bits), typedef round_key_t (128 bits);
//    - function xtime(8-bit);
//    - state enum {IDLE, EXPAND, DONE}.
//  - One sub-module, key_round_step:
//    - Combinational: prev round key + rcon -> next round key.
//    - Instantiates rot_word and one sub_word.
//  - key_sched_ctrl itself contains the FSM, the round counter, the rcon register and the 11 x 128 buffer.
// TESTING
//  - FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start for 1 cycle:
//    - busy=1 for 10 cycles;
//    - done pulses in cycle 11;
//    - rk[1] = a0fafe1788542cb123a339392a6c7605;
//    - rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
//  - All-zero key:
//    - rk[1] = 62636363626363636263636362636363;
//    - rk[10] = b4ef5bcb3e92e21123e951cf6f8f188e.
//  - start held high during EXPAND with a different key: ignored; the schedule matches the first key;
//    ready=0 throughout.
//  - Back-to-back: FIPS key, then the zero key accepted in DONE.
//    - key_valid drops the following cycle and returns 11 cycles later.
//    - rk[10] equals the zero-key value.
//  - Reset pulsed at cycle 5 of an expansion: all outputs return to reset values immediately;
//    rk_rd_data = 0 for every index.
//  - With KEYSCHED_ZEROIZE_EN: zeroize together with start in DONE -> state IDLE, key_valid=0,
//    every rk reads 0, start not taken.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and GF(2^8) helper.
package aes_pkg;

  localparam int Nb = 4;
  localparam int Nk = 4;
  localparam int Nr = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef logic [31:0]        word_t;
  typedef logic [Nk*32-1:0]   round_key_t;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

  // Multiply by x in GF(2^8), reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_round_step.sv
// Combinational AES-128 key-expansion step: previous round key + rcon -> next round key.
module key_round_step
  import aes_pkg::*;
(
  input  round_key_t  prev_i,
  input  logic [7:0]  rcon_i,
  output round_key_t  next_o
);

  word_t rot_w;
  word_t sub_w;
  word_t acc_w;

  rot_word u_rot (.w_i(prev_i[31:0]), .w_o(rot_w));
  sub_word u_sub (.w_i(rot_w),        .w_o(sub_w));

  // Each output word folds in the previous word of the new key, starting from t.
  always_comb begin
    next_o = '0;
    acc_w  = sub_w ^ {rcon_i, 24'h0};
    for (int i = 0; i < Nb; i++) begin
      acc_w = acc_w ^ prev_i[(Nb-1-i)*32 +: 32];
      next_o[(Nb-1-i)*32 +: 32] = acc_w;
    end
  end

endmodule

// File: rtl/rot_word.sv
// Cyclic left rotation of a word by one byte.
module rot_word
  import aes_pkg::*;
(
  input  word_t w_i,
  output word_t w_o
);

  assign w_o = {w_i[23:0], w_i[31:24]};

endmodule

// File: rtl/sub_word.sv
// Four parallel AES S-box lookups on one word.
module sub_word
  import aes_pkg::*;
(
  input  word_t w_i,
  output word_t w_o
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[(255 - int'(x)) * 8 +: 8];
  endfunction

  always_comb begin
    w_o = '0;
    for (int i = 0; i < 4; i++) begin
      w_o[8*i +: 8] = sbox(w_i[8*i +: 8]);
    end
  end

endmodule

// File: rtl/key_sched_ctrl.sv
// Sequential AES-128 key schedule: one round key per cycle into an 11-entry buffer with combinational read.
// Optional KEYSCHED_ZEROIZE_EN adds a zeroize input that clears the buffer and aborts expansion.
module key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int LENGTH = 128,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef KEYSCHED_ZEROIZE_EN
  input  logic              zeroize,
`endif
  input  logic              start,
  input  logic [LENGTH-1:0] key,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              key_valid,
  input  logic [IDX_W-1:0]  rk_rd_idx,
  output logic [LENGTH-1:0] rk_rd_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(Nr);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] round_q, round_d;
  logic [7:0]       rcon_q, rcon_d;
  logic             key_valid_q, key_valid_d;
  logic             done_q, done_d;
  round_key_t       rk_q [Nr+1];
  round_key_t       step_next;
  logic             accept;
  logic             zero_w;

`ifdef KEYSCHED_ZEROIZE_EN
  assign zero_w = zeroize;
`else
  assign zero_w = 1'b0;
`endif

  assign ready     = (state_q != EXPAND);
  assign busy      = (state_q == EXPAND);
  assign done      = done_q;
  assign key_valid = key_valid_q;
  assign accept    = start && ready;

  key_round_step u_step (
    .prev_i (rk_q[round_q - 1'b1]),
    .rcon_i (rcon_q),
    .next_o (step_next)
  );

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    rcon_d      = rcon_q;
    key_valid_d = key_valid_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d     = EXPAND;
          round_d     = 1;
          rcon_d      = RCON_INIT;
          key_valid_d = 1'b0;
        end
      end
      EXPAND: begin
        rcon_d = xtime(rcon_q);
        if (round_q == LAST_IDX) begin
          state_d     = DONE;
          done_d      = 1'b1;
          key_valid_d = 1'b1;
        end else begin
          round_d = round_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (zero_w) begin
      state_d     = IDLE;
      round_d     = '0;
      rcon_d      = RCON_INIT;
      key_valid_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_q     <= '0;
      rcon_q      <= RCON_INIT;
      key_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      rcon_q      <= rcon_d;
      key_valid_q <= key_valid_d;
      done_q      <= done_d;
    end
  end

  // Accept and EXPAND are mutually exclusive, so each cycle writes at most one entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= Nr; i++) rk_q[i] <= '0;
    end else if (zero_w) begin
      for (int i = 0; i <= Nr; i++) rk_q[i] <= '0;
    end else if (accept) begin
      rk_q[0] <= key;
    end else if (state_q == EXPAND) begin
      rk_q[round_q] <= step_next;
    end
  end

  assign rk_rd_data = (rk_rd_idx <= LAST_IDX) ? rk_q[rk_rd_idx] : '0;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: word-wise FIPS-197 reference with an S-box derived from GF(2^8) inversion.
module tb_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic         ready, busy, done, key_valid;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;
`ifdef KEYSCHED_ZEROIZE_EN
  logic         zeroize;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0]   msbox [256];
  logic [127:0] exp_rk [11];

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  always #5 clk = ~clk;

  key_sched_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef KEYSCHED_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .start      (start),
    .key        (key),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .key_valid  (key_valid),
    .rk_rd_idx  (rk_rd_idx),
    .rk_rd_data (rk_rd_data)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box = affine transform of the multiplicative inverse (a^254, with 0 -> 0).
  function automatic logic [7:0] sbox_of(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    repeat (254) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {msbox[t[31:24]], msbox[t[23:16]], msbox[t[15:8]], msbox[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_rd(input string tag, input int idx, input logic [127:0] exp_v);
    rk_rd_idx = 4'(idx);
    #1;
    chk(tag, rk_rd_data, exp_v);
  endtask

  task automatic chk_sched(input string tag);
    for (int i = 0; i < 16; i++)
      chk_rd($sformatf("%s_rk%0d", tag, i), i, (i <= 10) ? exp_rk[i] : 128'h0);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 16; i++) chk_rd($sformatf("%s_rk%0d", tag, i), i, 128'h0);
  endtask

  // Called at a negedge with ready=1; returns at the negedge of cycle 11 (state DONE).
  task automatic run_exp(input string tag, input logic [127:0] k, input bit hold, input logic [127:0] k2);
    model_expand(k);
    start = 1'b1;
    key   = k;
    for (int r = 1; r <= 10; r++) begin
      tick();
      if (hold && r < 10) begin
        start = 1'b1;
        key   = k2;
      end else begin
        start = 1'b0;
      end
      chk($sformatf("%s_c%0d_busy", tag, r),  busy,      1'b1);
      chk($sformatf("%s_c%0d_ready", tag, r), ready,     1'b0);
      chk($sformatf("%s_c%0d_done", tag, r),  done,      1'b0);
      chk($sformatf("%s_c%0d_kv", tag, r),    key_valid, 1'b0);
      chk_rd($sformatf("%s_c%0d_partial", tag, r), r - 1, exp_rk[r-1]);
    end
    tick();
    chk({tag, "_c11_done"},  done,      1'b1);
    chk({tag, "_c11_kv"},    key_valid, 1'b1);
    chk({tag, "_c11_busy"},  busy,      1'b0);
    chk({tag, "_c11_ready"}, ready,     1'b1);
  endtask

  initial begin
    logic [127:0] ka, kb;
    rst_n     = 1'b0;
    start     = 1'b0;
    key       = '0;
    rk_rd_idx = '0;
`ifdef KEYSCHED_ZEROIZE_EN
    zeroize   = 1'b0;
`endif
    for (int i = 0; i < 256; i++) msbox[i] = sbox_of(8'(i));

    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_done",  done,  1'b0);
    chk("rst_kv",    key_valid, 1'b0);
    chk_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 1'b0);

    run_exp("fips", FIPS_KEY, 1'b0, '0);
    chk_rd("fips_const_rk1", 1, FIPS_RK1);
    chk_rd("fips_const_rk10", 10, FIPS_RK10);
    chk_sched("fips");
    chk("fips_done_pulse_end", done, 1'b0);
    chk("fips_kv_hold", key_valid, 1'b1);

    run_exp("zero", 128'h0, 1'b0, '0);
    chk_rd("zero_const_rk1", 1, ZERO_RK1);
    chk_rd("zero_const_rk10", 10, ZERO_RK10);
    chk_sched("zero");

    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    run_exp("hold", ka, 1'b1, kb);
    chk_sched("hold");

    run_exp("b2b_a", FIPS_KEY, 1'b0, '0);
    run_exp("b2b_b", 128'h0, 1'b0, '0);
    chk_rd("b2b_rk10", 10, ZERO_RK10);
    chk_sched("b2b");

    for (int n = 0; n < 3; n++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      run_exp($sformatf("rnd%0d", n), ka, 1'b0, '0);
      chk_sched($sformatf("rnd%0d", n));
    end

    start = 1'b1;
    key   = {$urandom, $urandom, $urandom, $urandom};
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("mid_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 1'b1);
    chk("mid_rst_busy",  busy,  1'b0);
    chk("mid_rst_done",  done,  1'b0);
    chk("mid_rst_kv",    key_valid, 1'b0);
    chk_all_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 1'b0);

`ifdef KEYSCHED_ZEROIZE_EN
    ka = {$urandom, $urandom, $urandom, $urandom};
    run_exp("zpre", ka, 1'b0, '0);
    zeroize = 1'b1;
    start   = 1'b1;
    key     = {$urandom, $urandom, $urandom, $urandom};
    tick();
    zeroize = 1'b0;
    start   = 1'b0;
    chk("zero_kv",    key_valid, 1'b0);
    chk("zero_done",  done,      1'b0);
    chk("zero_busy",  busy,      1'b0);
    chk("zero_ready", ready,     1'b1);
    chk_all_zero("zeroize");
    @(negedge clk);
    tick();
    chk("zero_no_start", busy, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
